// File: rtl/lsu_arb_pkg.sv
// Shared types for the data-memory arbiter and its round-robin picker.
//   arb_state_e : arbiter FSM encoding (IDLE accepts a grant, BUSY waits for
//                 the fixed-latency memory response).
//   mem_cmd_t   : one memory command as presented by a requester.
//   MEM_LAT_MAX : largest supported memory latency.
// The command struct is sized for the default 32-bit address/data build;
// wider arbiter parameters are truncated into these fields.
package lsu_arb_pkg;

  localparam int MEM_LAT_MAX = 7;
  localparam int CMD_ADDR_W  = 32;
  localparam int CMD_DATA_W  = 32;
  localparam int CMD_MASK_W  = CMD_DATA_W / 8;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic                  wren;
    logic [CMD_ADDR_W-1:0] addr;
    logic [CMD_DATA_W-1:0] wdata;
    logic [CMD_MASK_W-1:0] bmask;
  } mem_cmd_t;

endpackage

// File: rtl/lsu_mem_arbiter_rr_pick2.sv
// Combinational 2-way round-robin picker, reusable for any shared port.
//   req_i[1:0] : requests
//   lst_i      : index of the requester served most recently
//   gnt_o[1:0] : one-hot grant (all zero when nobody requests)
//   win_o      : index of the winner (meaningful only when |req_i)
// A lone requester always wins; on a tie the one that was not served last wins.
module rr_pick2 (
  input  logic [1:0] req_i,
  input  logic       lst_i,
  output logic [1:0] gnt_o,
  output logic       win_o
);

  always_comb begin
    win_o = (req_i == 2'b11) ? ~lst_i : req_i[1];
    gnt_o = 2'b00;
    if (req_i != 2'b00) begin
      gnt_o = win_o ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/lsu_mem_arbiter.sv
// Shares the single data-memory port between the core LSU (requester 0) and
// the debug/DMA loader (requester 1). One transaction outstanding at a time;
// memory answers a fixed MEM_LAT cycles after the command strobe.
//   i_clk, i_rst            : clock, synchronous active-high reset
//   i_req*/i_wren*/i_addr*/i_wdata*/i_bmask* : requester commands
//   o_gnt*                  : command accepted this cycle (combinational)
//   o_rvalid*/o_rdata*      : one-cycle completion pulse and read data
//   o_mem_*                 : command to the memory macro, i_mem_rdata back
//   o_busy                  : a transaction is outstanding
// Handshake: a requester holds req and its fields stable until it sees gnt in
// the same cycle; it may withdraw by dropping req before gnt. Every accepted
// command (read or write) completes with exactly one rvalid at grant+MEM_LAT.
module lsu_mem_arbiter
  import lsu_arb_pkg::*;
#(
  parameter int MEM_LAT = 1,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_req0,
  input  logic                i_req1,
  input  logic                i_wren0,
  input  logic                i_wren1,
  input  logic [ADDR_W-1:0]   i_addr0,
  input  logic [ADDR_W-1:0]   i_addr1,
  input  logic [DATA_W-1:0]   i_wdata0,
  input  logic [DATA_W-1:0]   i_wdata1,
  input  logic [DATA_W/8-1:0] i_bmask0,
  input  logic [DATA_W/8-1:0] i_bmask1,
  output logic                o_gnt0,
  output logic                o_gnt1,
  output logic                o_rvalid0,
  output logic                o_rvalid1,
  output logic [DATA_W-1:0]   o_rdata0,
  output logic [DATA_W-1:0]   o_rdata1,
  output logic                o_mem_req,
  output logic                o_mem_wren,
  output logic [ADDR_W-1:0]   o_mem_addr,
  output logic [DATA_W-1:0]   o_mem_wdata,
  output logic [DATA_W/8-1:0] o_mem_bmask,
  input  logic [DATA_W-1:0]   i_mem_rdata,
  output logic                o_busy
);

  localparam int CW = $clog2(MEM_LAT + 1);

  arb_state_e  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        lst_q, lst_d;
  logic        owner_q, owner_d;
  logic        own_wr_q, own_wr_d;

  logic [1:0]  pick_gnt;
  logic        pick_w;
  mem_cmd_t    cmd0, cmd1, cmd_out;
  logic [1:0]  gnt, rvalid;
  logic        mem_req;
  logic [DATA_W-1:0] rdata;

  rr_pick2 u_pick (
    .req_i ({i_req1, i_req0}),
    .lst_i (lst_q),
    .gnt_o (pick_gnt),
    .win_o (pick_w)
  );

  always_comb begin
    cmd0.wren  = i_wren0;
    cmd0.addr  = CMD_ADDR_W'(i_addr0);
    cmd0.wdata = CMD_DATA_W'(i_wdata0);
    cmd0.bmask = CMD_MASK_W'(i_bmask0);
    cmd1.wren  = i_wren1;
    cmd1.addr  = CMD_ADDR_W'(i_addr1);
    cmd1.wdata = CMD_DATA_W'(i_wdata1);
    cmd1.bmask = CMD_MASK_W'(i_bmask1);
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    lst_d    = lst_q;
    owner_d  = owner_q;
    own_wr_d = own_wr_q;
    gnt      = 2'b00;
    rvalid   = 2'b00;
    mem_req  = 1'b0;
    cmd_out  = '0;
    rdata    = '0;
    unique case (state_q)
      ARB_IDLE: begin
        if (i_req0 || i_req1) begin
          gnt      = pick_gnt;
          mem_req  = 1'b1;
          cmd_out  = pick_w ? cmd1 : cmd0;
          lst_d    = pick_w;
          owner_d  = pick_w;
          own_wr_d = cmd_out.wren;
          cnt_d    = CW'(MEM_LAT);
          state_d  = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        cnt_d = cnt_q - CW'(1);
        // Counter reaching 1 marks the cycle the memory data is valid.
        if (cnt_q == CW'(1)) begin
          rvalid  = owner_q ? 2'b10 : 2'b01;
          rdata   = own_wr_q ? '0 : i_mem_rdata;
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
    // Outputs are combinational from state and requests, so they must be
    // silenced explicitly while reset is asserted.
    if (i_rst) begin
      gnt     = 2'b00;
      rvalid  = 2'b00;
      mem_req = 1'b0;
      cmd_out = '0;
      rdata   = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= ARB_IDLE;
      cnt_q    <= '0;
      lst_q    <= 1'b1;
      owner_q  <= 1'b0;
      own_wr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      lst_q    <= lst_d;
      owner_q  <= owner_d;
      own_wr_q <= own_wr_d;
    end
  end

  assign o_gnt0      = gnt[0];
  assign o_gnt1      = gnt[1];
  assign o_rvalid0   = rvalid[0];
  assign o_rvalid1   = rvalid[1];
  assign o_rdata0    = rvalid[0] ? rdata : '0;
  assign o_rdata1    = rvalid[1] ? rdata : '0;
  assign o_mem_req   = mem_req;
  assign o_mem_wren  = cmd_out.wren;
  assign o_mem_addr  = ADDR_W'(cmd_out.addr);
  assign o_mem_wdata = DATA_W'(cmd_out.wdata);
  assign o_mem_bmask = (DATA_W/8)'(cmd_out.bmask);
  assign o_busy      = (state_q == ARB_BUSY) && !i_rst;

endmodule
